// File: rtl/quot_to_bcd.sv
// Signed quotient to sign flag plus packed BCD magnitude, using an iterative
// shift-add-3 (double-dabble) loop of M iterations.
module quot_to_bcd #(
    parameter int M = 8,
    parameter int D = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M-1:0]   VALUE,
    output logic [4*D-1:0] BCD,
    output logic           SIGN,
    output logic           busy,
    output logic           done
);

    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        FINISH
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [M-1:0]   value_reg;
    logic [M-1:0]   mag;
    logic [4*D-1:0] scratch;
    logic [4*D-1:0] adjusted;
    logic           sign_reg;
    logic [CW-1:0]  count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (count == CW'(1)) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Add 3 to every digit of 5 or more so the following shift carries into the next decade.
    always_comb begin
        adjusted = scratch;
        for (int i = 0; i < D; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_reg <= '0;
            mag       <= '0;
            scratch   <= '0;
            sign_reg  <= 1'b0;
            count     <= '0;
            BCD       <= '0;
            SIGN      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (start) begin
                        value_reg <= VALUE;
                    end
                end
                LOAD: begin
                    // Negating as unsigned lets the most negative value map cleanly to 2^(M-1).
                    sign_reg <= value_reg[M-1];
                    mag      <= value_reg[M-1] ? (~value_reg + M'(1)) : value_reg;
                    scratch  <= '0;
                    count    <= CW'(M);
                end
                SHIFT: begin
                    scratch <= {adjusted[4*D-2:0], mag[M-1]};
                    mag     <= {mag[M-2:0], 1'b0};
                    count   <= count - CW'(1);
                end
                FINISH: begin
                    BCD  <= scratch;
                    SIGN <= sign_reg;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_quot_to_bcd.sv
// Scoreboard bench for quot_to_bcd (M=8, D=3): expected results are queued at
// stimulus time and popped by a monitor whenever done pulses.
module tb_quot_to_bcd;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  VALUE;
    logic [11:0] BCD;
    logic        SIGN;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    logic [12:0] expQ[$];
    int          doneTimes[$];

    quot_to_bcd #(.M(8), .D(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .VALUE (VALUE),
        .BCD   (BCD),
        .SIGN  (SIGN),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Decimal reference built with division, independent of the shift-add-3 method.
    function automatic logic [12:0] expOf(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return {(v < 0), 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            logic [12:0] e;
            doneTimes.push_back(cycle);
            total++;
            if (expQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_done: got sign=%b bcd=%h, required no done pulse", SIGN, BCD);
            end else begin
                e = expQ.pop_front();
                if ({SIGN, BCD} !== e) begin
                    bad++;
                    $display("[TB] FAIL result: got sign=%b bcd=%h, required sign=%b bcd=%h",
                             SIGN, BCD, e[12], e[11:0]);
                end
            end
        end
    end

    task automatic waitDone(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
        end
    endtask

    task automatic runOne(input int v, input string name);
        int n;
        @(negedge clk);
        VALUE = 8'(v);
        start = 1'b1;
        expQ.push_back(expOf(v));
        @(posedge clk);
        #1;
        start = 1'b0;
        VALUE = 8'h5a;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s busy_rise: got %b, required 1", name, busy);
        end
        waitDone(n);
        total++;
        if (done !== 1'b1 || n != 10) begin
            bad++;
            $display("[TB] FAIL %s latency: got done=%b after %0d edges, required done=1 after 10", name, done, n);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s busy_fall: got %b, required 0", name, busy);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s done_width: got %b, required 0", name, done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        VALUE = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({BCD, SIGN, busy, done} !== 15'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: got bcd=%h sign=%b busy=%b done=%b, required all 0", BCD, SIGN, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_values;
        runOne(100, "v100");
        runOne(-128, "vm128");
        runOne(127, "v127");
        repeat (5) @(posedge clk);
        #1;
        total++;
        if ({SIGN, BCD} !== 13'h0127) begin
            bad++;
            $display("[TB] FAIL hold: got sign=%b bcd=%h, required sign=0 bcd=127", SIGN, BCD);
        end
        runOne(-1, "vm1");
        runOne(0, "v0");
        runOne(59, "v59");
    endtask

    task automatic test_ignore_busy;
        int n;
        doneTimes.delete();
        @(negedge clk);
        VALUE = 8'd45;
        start = 1'b1;
        expQ.push_back(expOf(45));
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        VALUE = 8'd99;
        @(posedge clk);
        #1;
        start = 1'b0;
        VALUE = 8'd55;
        waitDone(n);
        total++;
        if (done !== 1'b1 || n != 7) begin
            bad++;
            $display("[TB] FAIL ignore_latency: got done=%b after %0d edges from E3, required 1 after 7", done, n);
        end
        repeat (25) @(posedge clk);
        #1;
        total++;
        if (doneTimes.size() != 1) begin
            bad++;
            $display("[TB] FAIL ignore_count: got %0d done pulses, required 1", doneTimes.size());
        end
    endtask

    task automatic test_back_to_back;
        int n;
        doneTimes.delete();
        @(negedge clk);
        VALUE = 8'd1;
        start = 1'b1;
        expQ.push_back(expOf(1));
        expQ.push_back(expOf(2));
        expQ.push_back(expOf(3));
        @(posedge clk);
        #1;
        VALUE = 8'd2;
        waitDone(n);
        @(posedge clk);
        #1;
        VALUE = 8'd3;
        waitDone(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        VALUE = 8'd9;
        waitDone(n);
        repeat (15) @(posedge clk);
        #1;
        total++;
        if (doneTimes.size() != 3) begin
            bad++;
            $display("[TB] FAIL b2b_count: got %0d done pulses, required 3", doneTimes.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                total++;
                if (doneTimes[i] - doneTimes[i-1] != 11) begin
                    bad++;
                    $display("[TB] FAIL b2b_spacing%0d: got %0d edges, required 11", i, doneTimes[i] - doneTimes[i-1]);
                end
            end
        end
    endtask

    task automatic test_reset_abort;
        doneTimes.delete();
        @(negedge clk);
        VALUE = 8'(-77);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({BCD, SIGN, busy, done} !== 15'd0) begin
            bad++;
            $display("[TB] FAIL abort_clear: got bcd=%h sign=%b busy=%b done=%b, required all 0", BCD, SIGN, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        total++;
        if (doneTimes.size() != 0 || BCD !== 12'h000) begin
            bad++;
            $display("[TB] FAIL abort_nodone: got %0d pulses bcd=%h, required 0 pulses bcd=000", doneTimes.size(), BCD);
        end
        runOne(-77, "vm77");
    endtask

    task automatic test_chained;
        int a;
        int b;
        int q;
        a = -100;
        b = 7;
        q = a / b;
        runOne(q, "chained");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_values();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_chained();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL leftover: got %0d pending results, required 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
